regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised successor to the single-cycle combinational register file.
- Clocked register array with NREAD combinational read ports and one synchronous write port.
- Per-register scoreboard busy bits track in-flight producers, so decode can detect RAW/WAW hazards and stall.
- Sits between the decode stage (reads and issue) and the writeback stage (write and scoreboard clear).

Parameters:
- XLEN, 32: data width of each register.
- NREGS, 32: number of architectural registers. Must be a power of two, at least 2.
- NREAD, 2: number of independent read ports, 1 to 4.
- ZERO_REG, 1: 1 means register 0 is hardwired to zero and never busy. 0 means register 0 is ordinary.
- AW, $clog2(NREGS): derived address width. Not to be overridden.

Ports:
- clk, in, 1: single clock, rising edge.
- reset, in, 1: asynchronous, active-high reset.
- raddr, in, NREAD*AW: read addresses; port i uses [i*AW +: AW].
- rdata, out, NREAD*XLEN: read data; port i uses [i*XLEN +: XLEN].
- rbusy, out, NREAD: scoreboard busy flag for the register addressed by each read port.
- issue_valid, in, 1: decode issues an instruction that will write issue_rd.
- issue_rd, in, AW: destination register of the issuing instruction.
- issue_ready, out, 1: issue is accepted this cycle.
- wb_valid, in, 1: writeback valid.
- wb_rd, in, AW: writeback destination register.
- wb_data, in, XLEN: writeback data.

Behaviour:
- Reset: asserting reset immediately clears all registers and all busy bits, including mid-operation, with no clock needed. While reset is high: rdata=0, rbusy=0, issue_ready=0. Writes and issues are ignored.
- Reads: combinational, zero latency.
  - rdata[i] = rf[raddr[i]].
  - rbusy[i] = busy[raddr[i]].
- Write: on a rising clk edge with wb_valid=1, rf[wb_rd] <= wb_data and busy[wb_rd] <= 0.
- Issue handshake:
  - issue_ready = !busy[issue_rd] || (wb_valid && wb_rd==issue_rd). WAW stall until the prior producer writes back.
  - When issue_valid && issue_ready, busy[issue_rd] <= 1 at the clock edge.
  - issue_ready does not depend on issue_valid.
- Simultaneous issue and writeback to the same register: the data write happens and busy ends at 1, because the new producer wins.
- Writeback to a non-busy register: the data is written and busy stays 0. This is legal and raises no error.
- ZERO_REG=1:
  - Reads of register 0 return 0 and rbusy=0.
  - Writes to register 0 are discarded.
  - Issue to register 0 is always ready and sets nothing.
- Read ports are fully independent. The same address on several ports returns identical results.
- No internal state besides rf[NREGS] and busy[NREGS].

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding. When wb_valid && wb_rd==raddr[i] (and not the hardwired register 0), rdata[i]=wb_data and rbusy[i]=0 in the same cycle.
- Undefined: reads see only the stored array. In the writeback cycle, rdata[i] holds the old value and rbusy[i] still reflects the pre-edge busy bit. The new value is visible the cycle after.

Test Plan:
1. Reset, then read all 32 registers on both ports -> rdata=0, rbusy=0. Assert reset mid-sequence after writing r5=0x1234 -> r5 reads 0 immediately.
2. Issue rd=7, next cycle raddr0=7 -> rbusy[0]=1, issue_ready with issue_rd=7 is 0. Then wb r7=0xDEADBEEF -> next cycle rbusy[0]=0, rdata0=0xDEADBEEF, issue_ready=1.
3. Same cycle wb_rd=3 (data 0xA5) and issue_rd=3 -> after the edge r3=0xA5 and busy[3]=1.
4. With REGFILE_BYPASS_EN, raddr1=9 and wb r9=0x55 in the same cycle -> rdata1=0x55, rbusy[1]=0 that cycle. Without the macro -> old value that cycle, 0x55 the next cycle.
5. ZERO_REG=1: wb r0=0xFFFFFFFF and issue rd=0 -> r0 reads 0, rbusy=0, issue_ready=1. ZERO_REG=0: r0 reads 0xFFFFFFFF.
6. NREAD=4, XLEN=64, NREGS=16: write distinct values to r1..r15, read four different addresses per cycle -> each port returns its own value.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Register file with NREAD combinational read ports, one writeback port and a per-register busy scoreboard.
// Optional REGFILE_BYPASS_EN: same-cycle writeback data and cleared busy are forwarded onto matching read ports.
module regfile_scoreboard #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREAD*AW-1:0]   raddr,
  output logic [NREAD*XLEN-1:0] rdata,
  output logic [NREAD-1:0]      rbusy,
  input  logic                  issue_valid,
  input  logic [AW-1:0]         issue_rd,
  output logic                  issue_ready,
  input  logic                  wb_valid,
  input  logic [AW-1:0]         wb_rd,
  input  logic [XLEN-1:0]       wb_data
);

  localparam bit HARD_ZERO = (ZERO_REG != 0);

  logic [XLEN-1:0]  rf_q [NREGS];
  logic [XLEN-1:0]  rf_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             wb_en;
  logic             issue_fire;

  // Register 0 never stores data nor becomes busy when hardwired.
  assign wb_en       = wb_valid && !(HARD_ZERO && (wb_rd == AW'(0)));
  assign issue_ready = !reset && (!busy_q[issue_rd] || (wb_valid && (wb_rd == issue_rd)));
  assign issue_fire  = issue_valid && issue_ready && !(HARD_ZERO && (issue_rd == AW'(0)));

  // Writeback clears busy first; a same-cycle issue to the same register re-marks it.
  always_comb begin
    rf_d   = rf_q;
    busy_d = busy_q;
    if (wb_en) begin
      rf_d[wb_rd]   = wb_data;
      busy_d[wb_rd] = 1'b0;
    end
    if (issue_fire) begin
      busy_d[issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        rf_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      rf_q   <= rf_d;
      busy_q <= busy_d;
    end
  end

  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit;

    assign addr = raddr[g*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    assign hit  = wb_en && (wb_rd == addr);
`else
    assign hit  = 1'b0;
`endif
    assign rdata[g*XLEN +: XLEN] = reset ? '0 : (hit ? wb_data : rf_q[addr]);
    assign rbusy[g]              = !reset && !hit && busy_q[addr];
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized and directed bench for regfile_scoreboard against an array-based reference model.
`timescale 1ns/1ps
module tb_regfile_scoreboard;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Default-configuration instance (XLEN=32, NREGS=32, NREAD=2, ZERO_REG=1)
  logic [4:0]  ra_a [2];
  logic [9:0]  raddr_a;
  logic [63:0] rdata_a;
  logic [31:0] rd_a [2];
  logic [1:0]  rbusy_a;
  logic        issue_valid, issue_ready_a, wb_valid;
  logic [4:0]  issue_rd, wb_rd;
  logic [31:0] wb_data;

  assign raddr_a = {ra_a[1], ra_a[0]};
  assign rd_a[0] = rdata_a[31:0];
  assign rd_a[1] = rdata_a[63:32];

  regfile_scoreboard dut_a (
    .clk(clk), .reset(reset), .raddr(raddr_a), .rdata(rdata_a), .rbusy(rbusy_a),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready_a),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  // Wide instance (XLEN=64, NREGS=16, NREAD=4, ZERO_REG=0)
  logic [3:0]   ra_b [4];
  logic [15:0]  raddr_b;
  logic [255:0] rdata_b;
  logic [63:0]  rd_b [4];
  logic [3:0]   rbusy_b;
  logic         issue_valid_b, issue_ready_b, wb_valid_b;
  logic [3:0]   issue_rd_b, wb_rd_b;
  logic [63:0]  wb_data_b;

  assign raddr_b = {ra_b[3], ra_b[2], ra_b[1], ra_b[0]};
  assign rd_b[0] = rdata_b[63:0];
  assign rd_b[1] = rdata_b[127:64];
  assign rd_b[2] = rdata_b[191:128];
  assign rd_b[3] = rdata_b[255:192];

  regfile_scoreboard #(.XLEN(64), .NREGS(16), .NREAD(4), .ZERO_REG(0)) dut_b (
    .clk(clk), .reset(reset), .raddr(raddr_b), .rdata(rdata_b), .rbusy(rbusy_b),
    .issue_valid(issue_valid_b), .issue_rd(issue_rd_b), .issue_ready(issue_ready_b),
    .wb_valid(wb_valid_b), .wb_rd(wb_rd_b), .wb_data(wb_data_b)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] m_rf [32];
  logic        m_busy [32];
  logic [63:0] exp_b [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int r = 0; r < 32; r++) begin
      m_rf[r]   = 32'h0;
      m_busy[r] = 1'b0;
    end
  endtask

  // Expected outputs of dut_a from the model state and the current inputs.
  task automatic cmp_a();
    for (int i = 0; i < 2; i++) begin
      logic [4:0]  a;
      logic [31:0] ed;
      logic        eb;
      a  = ra_a[i];
      ed = m_rf[a];
      eb = m_busy[a];
`ifdef REGFILE_BYPASS_EN
      if (wb_valid && (wb_rd == a) && (a != 5'd0)) begin
        ed = wb_data;
        eb = 1'b0;
      end
`endif
      if (reset) begin
        ed = 32'h0;
        eb = 1'b0;
      end
      chk($sformatf("rdata%0d", i), 64'(rd_a[i]), 64'(ed));
      chk($sformatf("rbusy%0d", i), 64'(rbusy_a[i]), 64'(eb));
    end
    chk("issue_ready", 64'(issue_ready_a),
        64'(!reset && (!m_busy[issue_rd] || (wb_valid && (wb_rd == issue_rd)))));
  endtask

  // Architectural effect of one clock edge on the model.
  task automatic model_update();
    logic rdy;
    if (reset) return;
    rdy = !m_busy[issue_rd] || (wb_valid && (wb_rd == issue_rd));
    if (wb_valid && (wb_rd != 5'd0)) begin
      m_rf[wb_rd]   = wb_data;
      m_busy[wb_rd] = 1'b0;
    end
    if (issue_valid && rdy && (issue_rd != 5'd0)) m_busy[issue_rd] = 1'b1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    cmp_a();
  endtask

  task automatic commit();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    issue_valid = 1'b0; issue_rd = 5'd0;
    wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
    ra_a[0] = 5'd0; ra_a[1] = 5'd0;
  endtask

  task automatic idle_b();
    issue_valid_b = 1'b0; issue_rd_b = 4'd0;
    wb_valid_b = 1'b0; wb_rd_b = 4'd0; wb_data_b = 64'h0;
    for (int j = 0; j < 4; j++) ra_b[j] = 4'd0;
  endtask

  initial begin
    reset = 1'b1;
    idle_a();
    idle_b();
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    ra_a[0] = 5'd3; ra_a[1] = 5'd17; issue_rd = 5'd4;
    at_neg();
    chk("reset_ready", 64'(issue_ready_a), 64'd0);
    reset = 1'b0;
    commit();

    // All registers read zero and not busy after reset
    for (int r = 0; r < 32; r++) begin
      ra_a[0] = 5'(r);
      ra_a[1] = 5'(31 - r);
      at_neg();
      commit();
    end

    // Asynchronous reset clears a written register without a clock
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
    at_neg();
    commit();
    idle_a();
    ra_a[0] = 5'd5;
    at_neg();
    chk("r5_written", 64'(rd_a[0]), 64'h1234);
    #1 reset = 1'b1;
    clear_model();
    #1 chk("r5_async_reset", 64'(rd_a[0]), 64'h0);
    cmp_a();
    @(posedge clk);
    #1 reset = 1'b0;

    // Issue r7, WAW stall, then writeback releases it
    issue_valid = 1'b1; issue_rd = 5'd7;
    at_neg();
    chk("issue7_ready", 64'(issue_ready_a), 64'd1);
    commit();
    issue_valid = 1'b0; ra_a[0] = 5'd7;
    at_neg();
    chk("r7_busy", 64'(rbusy_a[0]), 64'd1);
    chk("r7_waw_stall", 64'(issue_ready_a), 64'd0);
    commit();
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEADBEEF;
    at_neg();
    chk("r7_ready_on_wb", 64'(issue_ready_a), 64'd1);
    commit();
    wb_valid = 1'b0;
    at_neg();
    chk("r7_busy_clr", 64'(rbusy_a[0]), 64'd0);
    chk("r7_data", 64'(rd_a[0]), 64'hDEADBEEF);
    chk("r7_ready", 64'(issue_ready_a), 64'd1);
    commit();

    // Same-cycle writeback and issue to r3: data lands, busy stays set
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hA5;
    issue_valid = 1'b1; issue_rd = 5'd3;
    at_neg();
    commit();
    idle_a();
    ra_a[0] = 5'd3;
    at_neg();
    chk("r3_data", 64'(rd_a[0]), 64'hA5);
    chk("r3_busy", 64'(rbusy_a[0]), 64'd1);
    commit();

    // Read during writeback of r9
    ra_a[1] = 5'd9;
    wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h55;
    at_neg();
`ifdef REGFILE_BYPASS_EN
    chk("r9_bypass", 64'(rd_a[1]), 64'h55);
`else
    chk("r9_old", 64'(rd_a[1]), 64'h0);
`endif
    chk("r9_busy_wb", 64'(rbusy_a[1]), 64'd0);
    commit();
    wb_valid = 1'b0;
    at_neg();
    chk("r9_next", 64'(rd_a[1]), 64'h55);
    commit();

    // Hardwired register 0
    ra_a[0] = 5'd0;
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
    issue_valid = 1'b1; issue_rd = 5'd0;
    at_neg();
    chk("r0_ready", 64'(issue_ready_a), 64'd1);
    chk("r0_data_wb", 64'(rd_a[0]), 64'h0);
    commit();
    idle_a();
    at_neg();
    chk("r0_data", 64'(rd_a[0]), 64'h0);
    chk("r0_busy", 64'(rbusy_a[0]), 64'd0);
    commit();

    // Randomized traffic on a small register window to provoke hazards
    for (int c = 0; c < 800; c++) begin
      wb_valid    = 1'($urandom_range(0, 1));
      wb_rd       = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd    = 5'($urandom_range(0, 7));
      ra_a[0]     = 5'($urandom_range(0, 9));
      ra_a[1]     = ($urandom_range(0, 3) == 0) ? ra_a[0] : 5'($urandom_range(0, 31));
      at_neg();
      commit();
    end
    idle_a();

    // Wide instance: fill all registers, including ordinary r0
    for (int r = 0; r < 16; r++) begin
      exp_b[r]   = (r == 0) ? 64'hFFFFFFFF : {$urandom, $urandom};
      wb_valid_b = 1'b1;
      wb_rd_b    = 4'(r);
      wb_data_b  = exp_b[r];
      at_neg();
      commit();
    end
    wb_valid_b = 1'b0;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 4; j++) ra_b[j] = 4'(k + 5 * j);
      at_neg();
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("b_rdata%0d", j), rd_b[j], exp_b[ra_b[j]]);
        chk($sformatf("b_rbusy%0d", j), 64'(rbusy_b[j]), 64'd0);
      end
      commit();
    end
    issue_valid_b = 1'b1; issue_rd_b = 4'd0;
    at_neg();
    chk("b_r0_issue_ready", 64'(issue_ready_b), 64'd1);
    commit();
    issue_valid_b = 1'b0;
    ra_b[0] = 4'd0;
    at_neg();
    chk("b_r0_busy", 64'(rbusy_b[0]), 64'd1);
    chk("b_r0_stall", 64'(issue_ready_b), 64'd0);
    chk("b_r0_data", rd_b[0], 64'hFFFFFFFF);
    commit();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
